// File: rtl/l2_strm_prefetch_ctrl.sv
// Per-stream L2 slot bookkeeping, OpenCAPI prefetch issue, L1 read arbitration, drain-before-ack stream reset.
// Latency: read grant -> o_addr_v next cycle; prefetch grant -> o_req_v next cycle; response -> readable next cycle.
// Backpressure: o_req/o_addr are single output registers reloaded when empty or handshaking; i_rsp_r tied high.
// Optional: define L2_STRM_PF_ERR_CHK_EN to add the sticky o_err flag for unexpected responses.
module l2_strm_prefetch_ctrl #(
   parameter int NSTRMS = 16,
   parameter int SLOTS  = 16,
   parameter int SID_W  = $clog2(NSTRMS),
   parameter int PTR_W  = $clog2(SLOTS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PTR_W:0]    i_pf_depth,
   input  logic [NSTRMS-1:0] i_rst_v,
   output logic [NSTRMS-1:0] i_rst_r,
   output logic [NSTRMS-1:0] o_rst_v,
   input  logic [NSTRMS-1:0] o_rst_r,
   input  logic [NSTRMS-1:0] i_rd_v,
   output logic [NSTRMS-1:0] i_rd_r,
   output logic              o_addr_v,
   input  logic              o_addr_r,
   output logic [SID_W-1:0]  o_addr_sid,
   output logic [PTR_W-1:0]  o_addr_ptr,
   output logic              o_req_v,
   input  logic              o_req_r,
   output logic [SID_W-1:0]  o_req_sid,
   input  logic              i_rsp_v,
   output logic              i_rsp_r,
   input  logic [SID_W-1:0]  i_rsp_sid
`ifdef L2_STRM_PF_ERR_CHK_EN
   ,
   output logic              o_err
`endif
);

   localparam int CW = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ACK   = 2'd2,
      ST_RUN   = 2'd3
   } st_e;

   st_e              st_q     [NSTRMS];
   st_e              st_d     [NSTRMS];
   logic [PTR_W-1:0] rd_ptr_q [NSTRMS];
   logic [PTR_W-1:0] rd_ptr_d [NSTRMS];
   logic [PTR_W-1:0] wr_ptr_q [NSTRMS];
   logic [PTR_W-1:0] wr_ptr_d [NSTRMS];
   logic [CW-1:0]    valid_q  [NSTRMS];
   logic [CW-1:0]    valid_d  [NSTRMS];
   logic [CW-1:0]    outst_q  [NSTRMS];
   logic [CW-1:0]    outst_d  [NSTRMS];

   logic [CW-1:0]     depth_eff;
   logic [NSTRMS-1:0] rsp_ok;
   logic [NSTRMS-1:0] rst_hs;
   logic [NSTRMS-1:0] req_elig;
   logic [NSTRMS-1:0] rd_elig;

   logic             req_free, req_gnt, req_fire;
   logic             rd_free, rd_gnt, rd_fire;
   logic [SID_W-1:0] req_win, rd_win;
   logic [SID_W-1:0] req_rr_q, rd_rr_q;

   logic             o_req_v_q;
   logic [SID_W-1:0] o_req_sid_q;
   logic             o_addr_v_q;
   logic [SID_W-1:0] o_addr_sid_q;
   logic [PTR_W-1:0] o_addr_ptr_q;

   // Per-stream eligibility and event decode; a pending reset request masks both grants.
   always_comb begin
      depth_eff = (i_pf_depth > CW'(SLOTS)) ? CW'(SLOTS) : i_pf_depth;
      for (int s = 0; s < NSTRMS; s++) begin
         rsp_ok[s]   = i_rsp_v && (i_rsp_sid == SID_W'(s)) && (outst_q[s] != '0) &&
                       ((st_q[s] == ST_RUN) || (st_q[s] == ST_DRAIN));
         rst_hs[s]   = i_rst_v[s] && i_rst_r[s];
         req_elig[s] = (st_q[s] == ST_RUN) && !i_rst_v[s] &&
                       ((valid_q[s] + outst_q[s]) < depth_eff);
         rd_elig[s]  = (st_q[s] == ST_RUN) && i_rd_v[s] && !i_rst_v[s] &&
                       (valid_q[s] != '0);
      end
   end

   // Two independent round-robin arbiters, each searching from its pointer upward.
   always_comb begin
      req_gnt = 1'b0;
      req_win = req_rr_q;
      rd_gnt  = 1'b0;
      rd_win  = rd_rr_q;
      for (int i = 0; i < NSTRMS; i++) begin
         if (!req_gnt && req_elig[req_rr_q + SID_W'(i)]) begin
            req_gnt = 1'b1;
            req_win = req_rr_q + SID_W'(i);
         end
         if (!rd_gnt && rd_elig[rd_rr_q + SID_W'(i)]) begin
            rd_gnt = 1'b1;
            rd_win = rd_rr_q + SID_W'(i);
         end
      end
      req_free = !o_req_v_q || o_req_r;
      rd_free  = !o_addr_v_q || o_addr_r;
      req_fire = req_gnt && req_free;
      rd_fire  = rd_gnt && rd_free;
   end

   // Counter and pointer next-state; a reset handshake wipes the line state but keeps outst for draining.
   always_comb begin
      for (int s = 0; s < NSTRMS; s++) begin
         rd_ptr_d[s] = rd_ptr_q[s];
         wr_ptr_d[s] = wr_ptr_q[s];
         valid_d[s]  = valid_q[s];
         outst_d[s]  = outst_q[s];
         if (req_fire && (req_win == SID_W'(s))) begin
            outst_d[s] = outst_d[s] + CW'(1);
         end
         if (rsp_ok[s]) begin
            outst_d[s] = outst_d[s] - CW'(1);
         end
         if (rd_fire && (rd_win == SID_W'(s))) begin
            valid_d[s]  = valid_d[s] - CW'(1);
            rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
         end
         if (rsp_ok[s] && (st_q[s] == ST_RUN)) begin
            valid_d[s]  = valid_d[s] + CW'(1);
            wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
         end
         if (rst_hs[s]) begin
            rd_ptr_d[s] = '0;
            wr_ptr_d[s] = '0;
            valid_d[s]  = '0;
         end
      end
   end

   // Counter and pointer registers.
   always_ff @(posedge clk) begin
      for (int s = 0; s < NSTRMS; s++) begin
         if (reset) begin
            rd_ptr_q[s] <= '0;
            wr_ptr_q[s] <= '0;
            valid_q[s]  <= '0;
            outst_q[s]  <= '0;
         end else begin
            rd_ptr_q[s] <= rd_ptr_d[s];
            wr_ptr_q[s] <= wr_ptr_d[s];
            valid_q[s]  <= valid_d[s];
            outst_q[s]  <= outst_d[s];
         end
      end
   end

   // Stream FSM state register.
   always_ff @(posedge clk) begin
      for (int s = 0; s < NSTRMS; s++) begin
         if (reset) begin
            st_q[s] <= ST_IDLE;
         end else begin
            st_q[s] <= st_d[s];
         end
      end
   end

   // Stream FSM next state: reset drains in-flight requests before acknowledging.
   always_comb begin
      for (int s = 0; s < NSTRMS; s++) begin
         st_d[s] = st_q[s];
         case (st_q[s])
            ST_IDLE, ST_RUN: begin
               if (rst_hs[s]) begin
                  st_d[s] = (outst_d[s] != '0) ? ST_DRAIN : ST_ACK;
               end
            end
            ST_DRAIN: begin
               if (outst_d[s] == '0) begin
                  st_d[s] = ST_ACK;
               end
            end
            ST_ACK: begin
               if (o_rst_r[s]) begin
                  st_d[s] = ST_RUN;
               end
            end
            default: st_d[s] = ST_IDLE;
         endcase
      end
   end

   // Stream FSM outputs and registered port drive.
   always_comb begin
      for (int s = 0; s < NSTRMS; s++) begin
         i_rst_r[s] = (st_q[s] == ST_IDLE) || (st_q[s] == ST_RUN);
         o_rst_v[s] = (st_q[s] == ST_ACK);
         i_rd_r[s]  = rd_fire && (rd_win == SID_W'(s));
      end
      i_rsp_r    = 1'b1;
      o_req_v    = o_req_v_q;
      o_req_sid  = o_req_sid_q;
      o_addr_v   = o_addr_v_q;
      o_addr_sid = o_addr_sid_q;
      o_addr_ptr = o_addr_ptr_q;
   end

   // Prefetch request output register; sid holds while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_req_v_q   <= 1'b0;
         o_req_sid_q <= '0;
         req_rr_q    <= '0;
      end else if (req_free) begin
         o_req_v_q <= req_gnt;
         if (req_gnt) begin
            o_req_sid_q <= req_win;
            req_rr_q    <= req_win + SID_W'(1);
         end
      end
   end

   // URAM read-address output register; address holds while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_addr_v_q   <= 1'b0;
         o_addr_sid_q <= '0;
         o_addr_ptr_q <= '0;
         rd_rr_q      <= '0;
      end else if (rd_free) begin
         o_addr_v_q <= rd_gnt;
         if (rd_gnt) begin
            o_addr_sid_q <= rd_win;
            o_addr_ptr_q <= rd_ptr_q[rd_win];
            rd_rr_q      <= rd_win + SID_W'(1);
         end
      end
   end

`ifdef L2_STRM_PF_ERR_CHK_EN
   logic err_q;

   // Sticky flag for any response that no stream was expecting.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (i_rsp_v && (rsp_ok == '0)) begin
         err_q <= 1'b1;
      end
   end

   assign o_err = err_q;
`endif

endmodule

// File: tb/tb_l2_strm_prefetch_ctrl.sv
// Bench for l2_strm_prefetch_ctrl: directed scenarios plus randomized traffic against a queue-based stream model.
module tb_l2_strm_prefetch_ctrl;

   localparam int NSTRMS = 16;
   localparam int SLOTS  = 16;
   localparam int SID_W  = 4;
   localparam int PTR_W  = 4;

   localparam int M_IDLE  = 0;
   localparam int M_DRAIN = 1;
   localparam int M_ACK   = 2;
   localparam int M_RUN   = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [PTR_W:0]    i_pf_depth;
   logic [NSTRMS-1:0] i_rst_v, i_rst_r, o_rst_v, o_rst_r, i_rd_v, i_rd_r;
   logic              o_addr_v, o_addr_r;
   logic [SID_W-1:0]  o_addr_sid;
   logic [PTR_W-1:0]  o_addr_ptr;
   logic              o_req_v, o_req_r;
   logic [SID_W-1:0]  o_req_sid;
   logic              i_rsp_v, i_rsp_r;
   logic [SID_W-1:0]  i_rsp_sid;
`ifdef L2_STRM_PF_ERR_CHK_EN
   logic              o_err;
`endif

   always #5 clk = ~clk;

   l2_strm_prefetch_ctrl #(.NSTRMS(NSTRMS), .SLOTS(SLOTS), .SID_W(SID_W), .PTR_W(PTR_W)) dut (
      .clk(clk), .reset(reset), .i_pf_depth(i_pf_depth),
      .i_rst_v(i_rst_v), .i_rst_r(i_rst_r), .o_rst_v(o_rst_v), .o_rst_r(o_rst_r),
      .i_rd_v(i_rd_v), .i_rd_r(i_rd_r),
      .o_addr_v(o_addr_v), .o_addr_r(o_addr_r), .o_addr_sid(o_addr_sid), .o_addr_ptr(o_addr_ptr),
      .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_sid(o_req_sid),
      .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_sid(i_rsp_sid)
`ifdef L2_STRM_PF_ERR_CHK_EN
      , .o_err(o_err)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Stream model: lifecycle state, in-flight request count, and the slots of buffered lines in order.
   int m_st    [NSTRMS];
   int m_outst [NSTRMS];
   int m_lines [NSTRMS][$];
   int m_wr    [NSTRMS];
   int m_req_next, m_rd_next;
   bit e_req_v, e_addr_v, e_err;
   int e_req_sid, e_addr_sid, e_addr_ptr;
   logic [NSTRMS-1:0] m_rst_hs;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NSTRMS; s++) begin
         m_st[s] = M_IDLE;
         m_outst[s] = 0;
         m_lines[s].delete();
         m_wr[s] = 0;
      end
      m_req_next = 0;
      m_rd_next  = 0;
      e_req_v = 0; e_addr_v = 0; e_err = 0;
      e_req_sid = 0; e_addr_sid = 0; e_addr_ptr = 0;
      m_rst_hs = '0;
   endtask

   task automatic idle_inputs();
      i_rst_v = '0; o_rst_r = '0; i_rd_v = '0;
      i_rsp_v = 1'b0; i_rsp_sid = '0;
      o_req_r = 1'b1; o_addr_r = 1'b1;
   endtask

   // Global reset held over one rising edge, then reset values pinned as literals.
   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      i_pf_depth = '0;
      @(negedge clk);
      chk("rst_i_rst_r", 32'(i_rst_r), 32'h0000_FFFF);
      chk("rst_o_rst_v", 32'(o_rst_v), 32'h0);
      chk("rst_i_rd_r", 32'(i_rd_r), 32'h0);
      chk("rst_o_req_v", 32'(o_req_v), 32'h0);
      chk("rst_o_req_sid", 32'(o_req_sid), 32'h0);
      chk("rst_o_addr_v", 32'(o_addr_v), 32'h0);
      chk("rst_o_addr_sid", 32'(o_addr_sid), 32'h0);
      chk("rst_o_addr_ptr", 32'(o_addr_ptr), 32'h0);
`ifdef L2_STRM_PF_ERR_CHK_EN
      chk("rst_o_err", 32'(o_err), 32'h0);
`endif
      model_reset();
      reset = 1'b0;
   endtask

   // One clock: compare DUT against the model for the inputs now applied, then advance the model.
   task automatic cycle();
      int depth, rq_w, rd_w;
      bit rq_free, rd_free;
      logic [NSTRMS-1:0] e_rst_r, e_rst_v, e_rd_r;
      #1;
      depth = (int'(i_pf_depth) > SLOTS) ? SLOTS : int'(i_pf_depth);
      for (int s = 0; s < NSTRMS; s++) begin
         e_rst_r[s] = (m_st[s] == M_IDLE) || (m_st[s] == M_RUN);
         e_rst_v[s] = (m_st[s] == M_ACK);
      end
      rq_free = !e_req_v || o_req_r;
      rd_free = !e_addr_v || o_addr_r;
      rq_w = -1;
      rd_w = -1;
      for (int k = 0; k < NSTRMS; k++) begin
         int s;
         s = (m_req_next + k) % NSTRMS;
         if (rq_w < 0 && m_st[s] == M_RUN && !i_rst_v[s] && (m_lines[s].size() + m_outst[s] < depth))
            rq_w = s;
         s = (m_rd_next + k) % NSTRMS;
         if (rd_w < 0 && m_st[s] == M_RUN && !i_rst_v[s] && i_rd_v[s] && m_lines[s].size() > 0)
            rd_w = s;
      end
      e_rd_r = '0;
      if (rd_free && rd_w >= 0) e_rd_r[rd_w] = 1'b1;

      chk("i_rst_r", 32'(i_rst_r), 32'(e_rst_r));
      chk("o_rst_v", 32'(o_rst_v), 32'(e_rst_v));
      chk("i_rd_r", 32'(i_rd_r), 32'(e_rd_r));
      chk("i_rsp_r", 32'(i_rsp_r), 32'h1);
      chk("o_req_v", 32'(o_req_v), 32'(e_req_v));
      if (e_req_v) chk("o_req_sid", 32'(o_req_sid), 32'(e_req_sid));
      chk("o_addr_v", 32'(o_addr_v), 32'(e_addr_v));
      if (e_addr_v) begin
         chk("o_addr_sid", 32'(o_addr_sid), 32'(e_addr_sid));
         chk("o_addr_ptr", 32'(o_addr_ptr), 32'(e_addr_ptr));
      end
`ifdef L2_STRM_PF_ERR_CHK_EN
      chk("o_err", 32'(o_err), 32'(e_err));
`endif

      m_rst_hs = i_rst_v & e_rst_r;
      // Response validity is judged on start-of-cycle counts.
      if (i_rsp_v) begin
         int s;
         s = int'(i_rsp_sid);
         if ((m_st[s] == M_RUN || m_st[s] == M_DRAIN) && m_outst[s] > 0) begin
            m_outst[s]--;
            if (m_st[s] == M_RUN) begin
               m_lines[s].push_back(m_wr[s]);
               m_wr[s] = (m_wr[s] + 1) % SLOTS;
            end
         end else begin
            e_err = 1;
         end
      end
      if (rq_free) begin
         e_req_v = (rq_w >= 0);
         if (rq_w >= 0) begin
            e_req_sid = rq_w;
            m_outst[rq_w]++;
            m_req_next = (rq_w + 1) % NSTRMS;
         end
      end
      if (rd_free) begin
         e_addr_v = (rd_w >= 0);
         if (rd_w >= 0) begin
            e_addr_sid = rd_w;
            e_addr_ptr = m_lines[rd_w].pop_front();
            m_rd_next = (rd_w + 1) % NSTRMS;
         end
      end
      for (int s = 0; s < NSTRMS; s++) begin
         case (m_st[s])
            M_IDLE, M_RUN: if (m_rst_hs[s]) begin
               m_lines[s].delete();
               m_wr[s] = 0;
               m_st[s] = (m_outst[s] > 0) ? M_DRAIN : M_ACK;
            end
            M_DRAIN: if (m_outst[s] == 0) m_st[s] = M_ACK;
            M_ACK: if (o_rst_r[s]) m_st[s] = M_RUN;
            default: ;
         endcase
      end
      @(negedge clk);
   endtask

   // Random traffic that respects the reset-request hold rule.
   task automatic rand_drive();
      int cand[$];
      for (int s = 0; s < NSTRMS; s++) begin
         if (i_rst_v[s] && m_rst_hs[s]) i_rst_v[s] = 1'b0;
         else if (!i_rst_v[s] && $urandom_range(0, 99) < 2) i_rst_v[s] = 1'b1;
         if ((m_st[s] == M_RUN || m_st[s] == M_DRAIN) && m_outst[s] > 0) cand.push_back(s);
      end
      o_rst_r  = NSTRMS'($urandom);
      i_rd_v   = NSTRMS'($urandom);
      o_req_r  = ($urandom_range(0, 3) != 0);
      o_addr_r = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) i_pf_depth = (PTR_W+1)'($urandom_range(0, 31));
      i_rsp_v = 1'b0;
      if (cand.size() > 0 && $urandom_range(0, 99) < 60) begin
         i_rsp_v   = 1'b1;
         i_rsp_sid = SID_W'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 99) < 3) begin
         i_rsp_v   = 1'b1;
         i_rsp_sid = SID_W'($urandom);
      end
   endtask

   initial begin
      int order[3];
      order[0] = 0; order[1] = 5; order[2] = 9;
      reset = 1'b1;
      idle_inputs();
      i_pf_depth = '0;
      @(negedge clk);

      // Stream 3: bring-up, depth-limited prefetch, in-order reads.
      do_reset();
      i_pf_depth = 5'd4;
`ifdef L2_STRM_PF_ERR_CHK_EN
      i_rsp_v = 1'b1; i_rsp_sid = 4'd7; cycle(); i_rsp_v = 1'b0;
      chk("err_set", 32'(o_err), 32'h1);
      cycle(); cycle();
      chk("err_sticky", 32'(o_err), 32'h1);
`endif
      i_rst_v[3] = 1'b1; cycle(); i_rst_v[3] = 1'b0;
      chk("s3_ack", 32'(o_rst_v[3]), 32'h1);
      o_rst_r[3] = 1'b1; cycle(); o_rst_r[3] = 1'b0;
      chk("s3_req_t1", 32'(o_req_v), 32'h0);
      cycle();
      for (int k = 0; k < 4; k++) begin
         chk("s3_req_v", 32'(o_req_v), 32'h1);
         chk("s3_req_sid", 32'(o_req_sid), 32'h3);
         cycle();
      end
      chk("s3_req_stop", 32'(o_req_v), 32'h0);
      i_rsp_sid = 4'd3;
      for (int k = 0; k < 4; k++) begin
         i_rsp_v = 1'b1; cycle();
      end
      i_rsp_v = 1'b0;
      i_rd_v[3] = 1'b1; cycle();
      for (int k = 0; k < 4; k++) begin
         chk("s3_addr_v", 32'(o_addr_v), 32'h1);
         chk("s3_addr_ptr", 32'(o_addr_ptr), 32'(k));
         chk("s3_addr_sid", 32'(o_addr_sid), 32'h3);
         cycle();
      end
      i_rd_v[3] = 1'b0;
      chk("s3_addr_stop", 32'(o_addr_v), 32'h0);

      // Round-robin order across streams 0, 5, 9.
      do_reset();
      i_pf_depth = 5'd4;
      i_rst_v = 16'h0221; cycle(); i_rst_v = '0;
      o_rst_r = 16'h0221; cycle(); o_rst_r = '0;
      cycle();
      for (int k = 0; k < 6; k++) begin
         chk("rr_req_v", 32'(o_req_v), 32'h1);
         chk("rr_req_sid", 32'(o_req_sid), 32'(order[k % 3]));
         cycle();
      end

      // Stream 2 reset with 3 outstanding drains before acknowledging.
      do_reset();
      i_pf_depth = 5'd3;
      i_rst_v[2] = 1'b1; cycle(); i_rst_v[2] = 1'b0;
      o_rst_r[2] = 1'b1; cycle(); o_rst_r[2] = 1'b0;
      for (int k = 0; k < 5; k++) cycle();
      i_pf_depth = '0;
      i_rst_v[2] = 1'b1; cycle(); i_rst_v[2] = 1'b0;
      chk("s2_drain_rst_v", 32'(o_rst_v[2]), 32'h0);
      chk("s2_drain_rst_r", 32'(i_rst_r[2]), 32'h0);
      i_rd_v[2] = 1'b1;
      i_rsp_sid = 4'd2;
      for (int k = 0; k < 3; k++) begin
         i_rsp_v = 1'b1; cycle();
         chk("s2_drain_ack", 32'(o_rst_v[2]), (k == 2) ? 32'h1 : 32'h0);
         chk("s2_drain_noaddr", 32'(o_addr_v), 32'h0);
      end
      i_rsp_v = 1'b0;
      o_rst_r[2] = 1'b1; cycle(); o_rst_r[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("s2_no_lines", 32'(o_addr_v), 32'h0);
      end
      i_rd_v[2] = 1'b0;

      // Stream 1 at 15 valid lines: read and response together, write pointer wraps.
      do_reset();
      i_pf_depth = 5'd16;
      i_rst_v[1] = 1'b1; cycle(); i_rst_v[1] = 1'b0;
      o_rst_r[1] = 1'b1; cycle(); o_rst_r[1] = 1'b0;
      for (int k = 0; k < 20; k++) cycle();
      i_pf_depth = '0;
      i_rsp_sid = 4'd1;
      for (int k = 0; k < 15; k++) begin
         i_rsp_v = 1'b1; cycle();
      end
      i_rd_v[1] = 1'b1; i_rsp_v = 1'b1; cycle(); i_rsp_v = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("s1_addr_v", 32'(o_addr_v), 32'h1);
         chk("s1_addr_ptr", 32'(o_addr_ptr), 32'(k));
         cycle();
      end
      chk("s1_addr_stop", 32'(o_addr_v), 32'h0);
      i_rd_v[1] = 1'b0;

      // Randomized traffic across all streams.
      do_reset();
      i_pf_depth = 5'd8;
      for (int k = 0; k < 4000; k++) begin
         rand_drive();
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
